// File: rtl/cbb_rr_arb_pkg.sv
// Shared definitions for the round-robin arbiter: FSM state encoding and a
// constant-evaluable clog2 used for the index and hold-counter widths.
package cbb_rr_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/cbb_rr_arb_pick.sv
// Round-robin pick: first set request at or above ptr, wrapping to 0.
// Works on a doubled vector {req, req masked to >= ptr} so one upward scan covers the wrap.
module cbb_rr_arb_pick
    import cbb_rr_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   win_idx,
    output logic [NUM_REQ-1:0] win_onehot
);

    logic [NUM_REQ-1:0]   w_mask;
    logic [2*NUM_REQ-1:0] w_dbl;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
            assign w_mask[gi] = (32'(gi) >= 32'(ptr));
        end
    endgenerate

    assign w_dbl = {req, req & w_mask};

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        for (int i = 2 * NUM_REQ - 1; i >= 0; i--) begin
            if (w_dbl[i]) begin
                found   = 1'b1;
                win_idx = (i >= NUM_REQ) ? IDX_W'(i - NUM_REQ) : IDX_W'(i);
            end
        end
    end

    assign win_onehot = found ? (NUM_REQ'(1) << win_idx) : '0;

endmodule

// File: rtl/cbb_rr_arbiter.sv
// Round-robin arbiter holding a registered grant until done_i or request withdrawal.
// Optional forced release after MAX_HOLD cycles when CBB_RR_ARB_HOLD_LIMIT_EN is defined.
module cbb_rr_arbiter
    import cbb_rr_arb_pkg::*;
#(
    parameter  int NUM_REQ  = 4,
    parameter  int MAX_HOLD = 16,
    localparam int IDX_W    = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               done_i,
    output logic [NUM_REQ-1:0] gnt_onehot_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               gnt_vld_o,
    output logic               timeout_o
);

    arb_state_e         r_state, w_state_next;
    logic [IDX_W-1:0]   r_ptr, w_ptr_next;
    logic [NUM_REQ-1:0] r_gnt_onehot, w_gnt_onehot_next;
    logic [IDX_W-1:0]   r_gnt_idx, w_gnt_idx_next;
    logic               r_gnt_vld, w_gnt_vld_next;
    logic               w_new_grant;
    logic               w_force;
    logic               w_release;
    logic [IDX_W-1:0]   w_ptr_rel;
    logic [IDX_W-1:0]   w_pick_ptr;
    logic [NUM_REQ-1:0] w_pick_req;
    logic               w_found;
    logic [IDX_W-1:0]   w_win_idx;
    logic [NUM_REQ-1:0] w_win_onehot;

    assign w_release = (r_state == ST_GRANT) && (done_i || !req_i[r_gnt_idx] || w_force);
    assign w_ptr_rel = (r_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_gnt_idx + 1'b1;

    // On release the holder is masked out so it cannot win the same cycle.
    assign w_pick_ptr = w_release ? w_ptr_rel : r_ptr;
    assign w_pick_req = w_release ? (req_i & ~r_gnt_onehot) : req_i;

    cbb_rr_arb_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req        (w_pick_req),
        .ptr        (w_pick_ptr),
        .found      (w_found),
        .win_idx    (w_win_idx),
        .win_onehot (w_win_onehot)
    );

    always_comb begin
        w_state_next      = r_state;
        w_ptr_next        = r_ptr;
        w_gnt_onehot_next = r_gnt_onehot;
        w_gnt_idx_next    = r_gnt_idx;
        w_gnt_vld_next    = r_gnt_vld;
        w_new_grant       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_next      = ST_GRANT;
                    w_gnt_onehot_next = w_win_onehot;
                    w_gnt_idx_next    = w_win_idx;
                    w_gnt_vld_next    = 1'b1;
                    w_new_grant       = 1'b1;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    w_ptr_next = w_ptr_rel;
                    if (w_found) begin
                        w_gnt_onehot_next = w_win_onehot;
                        w_gnt_idx_next    = w_win_idx;
                        w_new_grant       = 1'b1;
                    end else begin
                        w_state_next      = ST_IDLE;
                        w_gnt_onehot_next = '0;
                        w_gnt_idx_next    = '0;
                        w_gnt_vld_next    = 1'b0;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_gnt_onehot <= '0;
            r_gnt_idx    <= '0;
            r_gnt_vld    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_ptr        <= w_ptr_next;
            r_gnt_onehot <= w_gnt_onehot_next;
            r_gnt_idx    <= w_gnt_idx_next;
            r_gnt_vld    <= w_gnt_vld_next;
        end
    end

`ifdef CBB_RR_ARB_HOLD_LIMIT_EN
    localparam int CNT_W = clog2(MAX_HOLD + 1);

    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_timeout;

    // Any other release cause wins, so a forced release never coincides with done_i.
    assign w_force = (r_state == ST_GRANT) && !done_i && req_i[r_gnt_idx]
                     && (r_hold_cnt == CNT_W'(MAX_HOLD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_force;
            if (w_new_grant || r_state != ST_GRANT) begin
                r_hold_cnt <= '0;
            end else begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

    assign timeout_o = r_timeout;
`else
    logic w_unused_hold;

    assign w_force       = 1'b0;
    assign w_unused_hold = ^{32'(MAX_HOLD), w_new_grant};
    assign timeout_o     = 1'b0;
`endif

    assign gnt_onehot_o = r_gnt_onehot;
    assign gnt_idx_o    = r_gnt_idx;
    assign gnt_vld_o    = r_gnt_vld;

endmodule

// File: tb/tb_cbb_rr_arbiter.sv
// Bench for cbb_rr_arbiter: vector table, hand-written corner sequences, and a
// randomized run against a rule-level reference model (honours CBB_RR_ARB_HOLD_LIMIT_EN).
module tb_cbb_rr_arbiter;

    localparam int N           = 4;
    localparam int TB_MAX_HOLD = 16;
`ifdef CBB_RR_ARB_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic         done = 1'b0;
    logic [N-1:0] gnt_onehot;
    logic [1:0]   gnt_idx;
    logic         gnt_vld;
    logic         timeout;

    logic         req1 = 1'b0;
    logic         done1 = 1'b0;
    logic [0:0]   gnt1_onehot;
    logic [0:0]   gnt1_idx;
    logic         gnt1_vld;
    logic         timeout1;

    cbb_rr_arbiter #(.NUM_REQ(N), .MAX_HOLD(TB_MAX_HOLD)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req),
        .done_i       (done),
        .gnt_onehot_o (gnt_onehot),
        .gnt_idx_o    (gnt_idx),
        .gnt_vld_o    (gnt_vld),
        .timeout_o    (timeout)
    );

    cbb_rr_arbiter #(.NUM_REQ(1), .MAX_HOLD(TB_MAX_HOLD)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req1),
        .done_i       (done1),
        .gnt_onehot_o (gnt1_onehot),
        .gnt_idx_o    (gnt1_idx),
        .gnt_vld_o    (gnt1_vld),
        .timeout_o    (timeout1)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit m_vld = 1'b0;
    int m_idx = 0;
    int m_ptr = 0;
    int m_hold = 0;
    bit m_to = 1'b0;
    bit m_new = 1'b0;

    typedef struct {
        logic         r;
        logic [N-1:0] q;
        logic         d;
        logic         e_vld;
        logic [1:0]   e_idx;
    } vec_t;

    localparam int NV = 34;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic r, input logic [N-1:0] q, input logic d,
                                input logic e_vld, input logic [1:0] e_idx);
        vec_t v;
        v.r = r; v.q = q; v.d = d; v.e_vld = e_vld; v.e_idx = e_idx;
        return v;
    endfunction

    function automatic int ref_pick(input logic [N-1:0] r, input int p);
        int j;
        for (int k = 0; k < N; k++) begin
            j = (p + k) % N;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_step(input logic r, input logic [N-1:0] q, input logic d);
        int w;
        logic [N-1:0] mq;
        bit forced;
        m_new = 1'b0;
        m_to  = 1'b0;
        if (r) begin
            m_vld = 1'b0; m_idx = 0; m_ptr = 0; m_hold = 0;
        end else if (!m_vld) begin
            w = ref_pick(q, m_ptr);
            if (w >= 0) begin
                m_vld = 1'b1; m_idx = w; m_hold = 0; m_new = 1'b1;
            end
        end else begin
            forced = HOLD_EN && !d && q[m_idx] && (m_hold == TB_MAX_HOLD - 1);
            if (d || !q[m_idx] || forced) begin
                m_to  = forced;
                m_ptr = (m_idx + 1) % N;
                mq = q;
                mq[m_idx] = 1'b0;
                w = ref_pick(mq, m_ptr);
                if (w >= 0) begin
                    m_idx = w; m_hold = 0; m_new = 1'b1;
                end else begin
                    m_vld = 1'b0; m_idx = 0; m_hold = 0;
                end
            end else begin
                m_hold++;
            end
        end
    endtask

    task automatic step(input logic r, input logic [N-1:0] q, input logic d);
        rst  = r;
        req  = q;
        done = d;
        @(posedge clk);
        #1;
        model_step(r, q, d);
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] obs();
        return {gnt_vld, gnt_idx, gnt_onehot, timeout};
    endfunction

    function automatic logic [7:0] expect_of(input logic v, input logic [1:0] i, input logic t);
        logic [N-1:0] oh;
        oh = v ? (4'b0001 << i) : 4'b0000;
        return {v, v ? i : 2'b00, oh, t};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [N-1:0] rq;
        logic rd, rr;

        vecs[0]  = mk(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0);
        vecs[1]  = mk(1'b0, 4'b0100, 1'b0, 1'b1, 2'd2);
        vecs[2]  = mk(1'b0, 4'b0100, 1'b0, 1'b1, 2'd2);
        vecs[3]  = mk(1'b0, 4'b0100, 1'b0, 1'b1, 2'd2);
        vecs[4]  = mk(1'b0, 4'b0100, 1'b0, 1'b1, 2'd2);
        vecs[5]  = mk(1'b0, 4'b0100, 1'b1, 1'b0, 2'd0);
        vecs[6]  = mk(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
        vecs[7]  = mk(1'b0, 4'b1001, 1'b0, 1'b1, 2'd3);
        vecs[8]  = mk(1'b0, 4'b1001, 1'b1, 1'b1, 2'd0);
        vecs[9]  = mk(1'b0, 4'b1001, 1'b0, 1'b1, 2'd0);
        vecs[10] = mk(1'b0, 4'b1001, 1'b1, 1'b1, 2'd3);
        vecs[11] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
        vecs[12] = mk(1'b0, 4'b0010, 1'b0, 1'b1, 2'd1);
        vecs[13] = mk(1'b0, 4'b0100, 1'b0, 1'b1, 2'd2);
        vecs[14] = mk(1'b0, 4'b0100, 1'b1, 1'b0, 2'd0);
        vecs[15] = mk(1'b0, 4'b0010, 1'b0, 1'b1, 2'd1);
        vecs[16] = mk(1'b1, 4'b0010, 1'b0, 1'b0, 2'd0);
        vecs[17] = mk(1'b0, 4'b0010, 1'b0, 1'b1, 2'd1);
        vecs[18] = mk(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0);
        vecs[19] = mk(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0);
        vecs[20] = mk(1'b0, 4'b1111, 1'b0, 1'b1, 2'd0);
        vecs[21] = mk(1'b0, 4'b1111, 1'b0, 1'b1, 2'd0);
        vecs[22] = mk(1'b0, 4'b1111, 1'b1, 1'b1, 2'd1);
        vecs[23] = mk(1'b0, 4'b1111, 1'b0, 1'b1, 2'd1);
        vecs[24] = mk(1'b0, 4'b1111, 1'b0, 1'b1, 2'd1);
        vecs[25] = mk(1'b0, 4'b1111, 1'b1, 1'b1, 2'd2);
        vecs[26] = mk(1'b0, 4'b1111, 1'b0, 1'b1, 2'd2);
        vecs[27] = mk(1'b0, 4'b1111, 1'b0, 1'b1, 2'd2);
        vecs[28] = mk(1'b0, 4'b1111, 1'b1, 1'b1, 2'd3);
        vecs[29] = mk(1'b0, 4'b1111, 1'b0, 1'b1, 2'd3);
        vecs[30] = mk(1'b0, 4'b1111, 1'b0, 1'b1, 2'd3);
        vecs[31] = mk(1'b0, 4'b1111, 1'b1, 1'b1, 2'd0);
        vecs[32] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
        vecs[33] = mk(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0);

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].r, vecs[i].q, vecs[i].d);
            $display("[TB] vec %0d rst=%b req=%b done=%b -> vld=%b idx=%0d onehot=%b",
                     i, vecs[i].r, vecs[i].q, vecs[i].d, gnt_vld, gnt_idx, gnt_onehot);
            check($sformatf("vec%0d", i), int'(obs()),
                  int'(expect_of(vecs[i].e_vld, vecs[i].e_idx, 1'b0)));
        end

        // Single-requester instance: release forces at least one idle cycle.
        req1 = 1'b0; done1 = 1'b0;
        step(1'b1, 4'b0000, 1'b0);
        check("n1_reset", int'({gnt1_vld, gnt1_idx, gnt1_onehot, timeout1}), 0);
        req1 = 1'b1;
        step(1'b0, 4'b0000, 1'b0);
        $display("[TB] n1 request -> vld=%b", gnt1_vld);
        check("n1_grant", int'({gnt1_vld, gnt1_idx, gnt1_onehot, timeout1}), 4'b1010);
        done1 = 1'b1;
        step(1'b0, 4'b0000, 1'b0);
        $display("[TB] n1 done -> vld=%b", gnt1_vld);
        check("n1_release_gap", int'(gnt1_vld), 0);
        done1 = 1'b0;
        step(1'b0, 4'b0000, 1'b0);
        $display("[TB] n1 re-request -> vld=%b", gnt1_vld);
        check("n1_regrant", int'(gnt1_vld), 1);
        req1 = 1'b0;
        step(1'b0, 4'b0000, 1'b0);
        check("n1_withdraw", int'(gnt1_vld), 0);

`ifdef CBB_RR_ARB_HOLD_LIMIT_EN
        // Held request without done: forced release after TB_MAX_HOLD cycles.
        step(1'b1, 4'b0000, 1'b0);
        step(1'b0, 4'b0001, 1'b0);
        cnt = 0;
        while (gnt_vld && cnt < 4 * TB_MAX_HOLD) begin
            cnt++;
            step(1'b0, 4'b0001, 1'b0);
        end
        $display("[TB] hold limit: grant held %0d cycles, timeout=%b", cnt, timeout);
        check("hold_len", cnt, TB_MAX_HOLD);
        check("timeout_pulse", int'({gnt_vld, timeout}), 2'b01);
        step(1'b0, 4'b0001, 1'b0);
        check("after_timeout", int'(obs()), int'(expect_of(1'b1, 2'd0, 1'b0)));
`endif

        // Randomized run against the reference model.
        step(1'b1, 4'b0000, 1'b0);
        check("rand_reset", int'(obs()), 0);
        rq = '0;
        for (int c = 0; c < 1200; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(7) == 0) rq[b] = ~rq[b];
            end
            rd = ($urandom_range(3) == 0);
            rr = ($urandom_range(249) == 0);
            step(rr, rq, rd);
            if (m_new) begin
                $display("[TB] rand cycle %0d: grant idx %0d (req=%b done=%b)", c, m_idx, rq, rd);
            end
            check($sformatf("rand%0d", c), int'(obs()),
                  int'(expect_of(m_vld, 2'(m_idx), m_to)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
